countn: RTL

Parametrised up/down counter: the next generation of the team's fixed 4-bit counter. Adds configurable width and modulus, a direction input, synchronous parallel load, a selectable wrap or saturate mode, and registered boundary flags. It is the general-purpose counter for timers, address generators and loop control in the datapath labs.

---
 rtl/countn_pkg.sv | 23 ++
 rtl/countn_if.sv | 26 ++
 rtl/countn_incdec_n.sv | 23 ++
 rtl/countn.sv | 87 ++++++++
 4 files changed

// File: rtl/countn_pkg.sv
// countn_pkg: shared definitions for the countn counter family.
//   count_mode_e   : MODE_WRAP (wrap at the bounds) / MODE_SAT (hold at the bounds)
//   params_legal() : elaboration-time legality check for WIDTH / MODULUS
package countn_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // MODULUS is carried as 64 bits so 2**32 is representable.
  function automatic bit params_legal(input int unsigned width,
                                      input longint unsigned modulus);
    if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
    if (modulus < 64'd2) return 1'b0;
    if (modulus > (64'd1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/countn_if.sv
// countn_if: control and status bundle of the countn counter.
//   master : drives enable, up, load, load_value; observes the status
//   slave  : the counter itself; drives count, at_max, at_min, wrapped, saturated
interface countn_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrapped;
  logic             saturated;

  modport master (
    output enable, up, load, load_value,
    input  count, at_max, at_min, wrapped, saturated
  );

  modport slave (
    input  enable, up, load, load_value,
    output count, at_max, at_min, wrapped, saturated
  );
endinterface

// File: rtl/countn_incdec_n.sv
// incdec_n: generalised WIDTH-bit incrementer/decrementer.
//   x   : operand
//   dir : 1 = x+1, 0 = x-1
//   y   : result, truncated to WIDTH bits
//   co  : carry out (dir=1) or borrow out (dir=0)
module incdec_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic             dir,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  always_comb begin
    if (dir) begin
      {co, y} = {1'b0, x} + (WIDTH+1)'(1);
    end else begin
      {co, y} = {1'b0, x} - (WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/countn.sv
// countn: parametrised up/down counter with load, wrap/saturate mode and
// registered boundary flags.
//   clock : single clock, all state changes on posedge
//   reset : synchronous, active-high, overrides everything
//   bus   : countn_if.slave
//     enable/up/load/load_value in; count, at_max, at_min (combinational
//     compares of count), wrapped, saturated (registered) out
module countn
  import countn_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter count_mode_e     MODE    = MODE_WRAP
) (
  input  logic    clock,
  input  logic    reset,
  countn_if.slave bus
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
    $error("countn: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q;
  logic             wrapped_q;
  logic             saturated_q;
  logic [WIDTH-1:0] step_value;
  logic             incdec_carry_unused;
  logic             at_max_c;
  logic             at_min_c;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  incdec_n #(
    .WIDTH(WIDTH)
  ) u_incdec (
    .x   (count_q),
    .dir (bus.up),
    .y   (step_value),
    .co  (incdec_carry_unused)
  );

  always_comb begin
    at_max_c = (count_q == MAX_COUNT);
    at_min_c = (count_q == '0);
    // Bound in the current direction; decided by compare, not by the
    // incrementer carry, so non-power-of-two moduli wrap correctly.
    at_bound = bus.up ? at_max_c : at_min_c;
    load_clamped = (64'(bus.load_value) < MODULUS) ? bus.load_value : MAX_COUNT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else if (bus.load) begin
      count_q     <= load_clamped;
      wrapped_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else if (bus.enable) begin
      if (!at_bound) begin
        count_q     <= step_value;
        wrapped_q   <= 1'b0;
        saturated_q <= 1'b0;
      end else if (MODE == MODE_WRAP) begin
        count_q     <= bus.up ? '0 : MAX_COUNT;
        wrapped_q   <= 1'b1;
        saturated_q <= 1'b0;
      end else begin
        wrapped_q   <= 1'b0;
        saturated_q <= 1'b1;
      end
    end else begin
      wrapped_q <= 1'b0;
    end
  end

  assign bus.count     = count_q;
  assign bus.at_max    = at_max_c;
  assign bus.at_min    = at_min_c;
  assign bus.wrapped   = wrapped_q;
  assign bus.saturated = saturated_q;

endmodule
